// File: rtl/ipg_pkg.sv
// Shared constants and helpers for the IPG message-insertion TX and RX paths.
// Block-type byte of a message block = {position nibble, message-type nibble}.
package ipg_pkg;

    localparam logic [1:0] SYNC_DATA = 2'b10;
    localparam logic [1:0] SYNC_CTRL = 2'b01;

    localparam logic [7:0] BLOCK_TYPE_CTRL         = 8'h1e;
    localparam logic [7:0] BLOCK_TYPE_FIRST_READ   = 8'h0a;
    localparam logic [7:0] BLOCK_TYPE_FIRST_RRESP  = 8'h0b;
    localparam logic [7:0] BLOCK_TYPE_FIRST_WRITE  = 8'h0c;
    localparam logic [7:0] BLOCK_TYPE_MIDDLE_READ  = 8'h1a;
    localparam logic [7:0] BLOCK_TYPE_MIDDLE_RRESP = 8'h1b;
    localparam logic [7:0] BLOCK_TYPE_MIDDLE_WRITE = 8'h1c;
    localparam logic [7:0] BLOCK_TYPE_LAST_READ    = 8'h2a;
    localparam logic [7:0] BLOCK_TYPE_LAST_RRESP   = 8'h2b;
    localparam logic [7:0] BLOCK_TYPE_LAST_WRITE   = 8'h2c;

    typedef enum logic [1:0] {
        MSG_READ  = 2'd0,
        MSG_RRESP = 2'd1,
        MSG_WRITE = 2'd2,
        MSG_RSVD  = 2'd3
    } msg_type_t;

    localparam logic [3:0] POS_FIRST  = 4'h0;
    localparam logic [3:0] POS_MIDDLE = 4'h1;
    localparam logic [3:0] POS_LAST   = 4'h2;

    // A slot is an all-idle control block; any non-zero control character rules it out.
    function automatic logic is_slot(input logic [1:0] hdr, input logic [63:0] data);
        return (hdr == SYNC_CTRL) && (data[7:0] == BLOCK_TYPE_CTRL) && (data[63:8] == 56'd0);
    endfunction

    function automatic logic [7:0] block_type(input logic [1:0] mtype, input logic [3:0] pos);
        logic [3:0] base;
        case (mtype)
            MSG_READ:  base = 4'ha;
            MSG_RRESP: base = 4'hb;
            MSG_WRITE: base = 4'hc;
            default:   base = 4'ha;
        endcase
        return {pos, base};
    endfunction

endpackage

// File: rtl/ipg_tx.sv
// Inserts 56-bit message chunks into idle control blocks of the 64b/66b TX stream.
// Every block, inserted or passed through, leaves exactly one cycle after it arrives.
module ipg_tx
    import ipg_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       encoded_tx_hdr,
    input  logic [63:0]      encoded_tx_data,
    output logic [1:0]       ipg_tx_hdr,
    output logic [63:0]      ipg_tx_data,
    input  logic             msg_valid,
    output logic             msg_ready,
    input  logic [1:0]       msg_type,
    input  logic [55:0]      msg_data,
    input  logic             msg_last,
    output logic             in_msg,
    output logic             type_err,
    output logic [CNT_W-1:0] insert_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DROP = 2'd2;

    // Handshake: msg_ready is high exactly when the current input block is an idle slot,
    // independent of msg_valid; a chunk moves when msg_valid && msg_ready, and the source
    // holds msg_* stable while valid and not ready.

    logic [1:0]       state_q, state_d;
    logic [1:0]       type_q, type_d;
    logic [1:0]       hdr_q;
    logic [63:0]      data_q;
    logic             type_err_q;
    logic [CNT_W-1:0] insert_q, stall_q;

    logic       slot, xfer, insert, err;
    logic [1:0] eff_type;
    logic [3:0] pos;

    assign slot      = is_slot(encoded_tx_hdr, encoded_tx_data);
    assign msg_ready = slot;
    assign xfer      = msg_valid && slot;

    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        insert   = 1'b0;
        err      = 1'b0;
        eff_type = msg_type;
        pos      = POS_FIRST;
        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    if (msg_type == MSG_RSVD) begin
                        err = 1'b1;
                        if (!msg_last) state_d = ST_DROP;
                    end else begin
                        insert = 1'b1;
                        pos    = msg_last ? POS_LAST : POS_FIRST;
                        if (!msg_last) begin
                            state_d = ST_BUSY;
                            type_d  = msg_type;
                        end
                    end
                end
            end
            ST_BUSY: begin
                // Continuation chunks reuse the type latched on the first chunk.
                eff_type = type_q;
                if (xfer) begin
                    insert = 1'b1;
                    pos    = msg_last ? POS_LAST : POS_MIDDLE;
                    if (msg_last) state_d = ST_IDLE;
                end
            end
            ST_DROP: begin
                if (xfer && msg_last) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            type_q     <= 2'd0;
            hdr_q      <= SYNC_CTRL;
            data_q     <= {56'd0, BLOCK_TYPE_CTRL};
            type_err_q <= 1'b0;
            insert_q   <= '0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            type_q     <= type_d;
            type_err_q <= err;
            if (insert) begin
                hdr_q  <= SYNC_CTRL;
                data_q <= {msg_data, block_type(eff_type, pos)};
            end else begin
                hdr_q  <= encoded_tx_hdr;
                data_q <= encoded_tx_data;
            end
            // Counters stick at all-ones instead of wrapping.
            if (insert && (insert_q != '1)) insert_q <= insert_q + CNT_W'(1);
            if (msg_valid && !slot && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign ipg_tx_hdr  = hdr_q;
    assign ipg_tx_data = data_q;
    assign in_msg      = (state_q == ST_BUSY);
    assign type_err    = type_err_q;
    assign insert_cnt  = insert_q;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_ipg_tx.sv
// Directed bench for ipg_tx: insertion, multi-chunk sequencing, stalls, reserved-type drop,
// asynchronous reset and counter saturation (on a narrow-counter second instance).
module tb_ipg_tx;

    logic        clk;
    logic        rst_n;
    logic [1:0]  encoded_tx_hdr;
    logic [63:0] encoded_tx_data;
    logic [1:0]  ipg_tx_hdr;
    logic [63:0] ipg_tx_data;
    logic        msg_valid;
    logic        msg_ready;
    logic [1:0]  msg_type;
    logic [55:0] msg_data;
    logic        msg_last;
    logic        in_msg;
    logic        type_err;
    logic [31:0] insert_cnt;
    logic [31:0] stall_cnt;

    logic [1:0]  s_hdr;
    logic [63:0] s_data;
    logic        s_ready;
    logic        s_in_msg;
    logic        s_type_err;
    logic [3:0]  s_insert_cnt;
    logic [3:0]  s_stall_cnt;

    int n_checks;
    int n_fail;

    localparam logic [63:0] IDLE_BLK = 64'h0000_0000_0000_001e;

    ipg_tx #(.CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .encoded_tx_hdr(encoded_tx_hdr), .encoded_tx_data(encoded_tx_data),
        .ipg_tx_hdr(ipg_tx_hdr), .ipg_tx_data(ipg_tx_data),
        .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_type(msg_type),
        .msg_data(msg_data), .msg_last(msg_last),
        .in_msg(in_msg), .type_err(type_err),
        .insert_cnt(insert_cnt), .stall_cnt(stall_cnt)
    );

    ipg_tx #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n),
        .encoded_tx_hdr(encoded_tx_hdr), .encoded_tx_data(encoded_tx_data),
        .ipg_tx_hdr(s_hdr), .ipg_tx_data(s_data),
        .msg_valid(msg_valid), .msg_ready(s_ready), .msg_type(msg_type),
        .msg_data(msg_data), .msg_last(msg_last),
        .in_msg(s_in_msg), .type_err(s_type_err),
        .insert_cnt(s_insert_cnt), .stall_cnt(s_stall_cnt)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks: inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_blk(input logic [1:0] hdr, input logic [63:0] data);
        encoded_tx_hdr  = hdr;
        encoded_tx_data = data;
    endtask

    task automatic drive_msg(input logic v, input logic [1:0] t, input logic [55:0] d, input logic l);
        msg_valid = v;
        msg_type  = t;
        msg_data  = d;
        msg_last  = l;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_blk(2'b01, IDLE_BLK);
        drive_msg(1'b0, 2'd0, 56'd0, 1'b0);
        step();
        step();
        n_checks++;
        if (ipg_tx_hdr !== 2'b01) begin n_fail++; $display("FAIL reset_hdr: got %b want 01", ipg_tx_hdr); end
        n_checks++;
        if (ipg_tx_data !== IDLE_BLK) begin n_fail++; $display("FAIL reset_data: got %h want %h", ipg_tx_data, IDLE_BLK); end
        n_checks++;
        if ({in_msg, type_err} !== 2'b00) begin n_fail++; $display("FAIL reset_flags: got %b want 00", {in_msg, type_err}); end
        n_checks++;
        if ((insert_cnt !== 32'd0) || (stall_cnt !== 32'd0)) begin
            n_fail++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", insert_cnt, stall_cnt);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_single();
        drive_blk(2'b01, IDLE_BLK);
        drive_msg(1'b1, 2'd0, 56'h11223344556677, 1'b1);
        #1;
        n_checks++;
        if (msg_ready !== 1'b1) begin n_fail++; $display("FAIL single_ready: got %b want 1", msg_ready); end
        step();
        drive_msg(1'b0, 2'd0, 56'd0, 1'b0);
        n_checks++;
        if ({ipg_tx_hdr, ipg_tx_data} !== {2'b01, 64'h112233445566772a}) begin
            n_fail++; $display("FAIL single_blk: got %b/%h want 01/112233445566772a", ipg_tx_hdr, ipg_tx_data);
        end
        n_checks++;
        if ((insert_cnt !== 32'd1) || (in_msg !== 1'b0)) begin
            n_fail++; $display("FAIL single_cnt: got cnt %0d in_msg %b want 1/0", insert_cnt, in_msg);
        end
    endtask

    task automatic test_multi();
        drive_blk(2'b01, IDLE_BLK);
        drive_msg(1'b1, 2'd2, 56'hA0A1A2A3A4A5A6, 1'b0);
        step();
        n_checks++;
        if ({ipg_tx_data, in_msg} !== {64'hA0A1A2A3A4A5A60c, 1'b1}) begin
            n_fail++; $display("FAIL multi_first: got %h in_msg %b want a0a1a2a3a4a5a60c/1", ipg_tx_data, in_msg);
        end
        drive_msg(1'b1, 2'd0, 56'hB0B1B2B3B4B5B6, 1'b0);
        step();
        n_checks++;
        if ({ipg_tx_data, in_msg} !== {64'hB0B1B2B3B4B5B61c, 1'b1}) begin
            n_fail++; $display("FAIL multi_middle: got %h in_msg %b want b0b1b2b3b4b5b61c/1", ipg_tx_data, in_msg);
        end
        drive_msg(1'b1, 2'd0, 56'hC0C1C2C3C4C5C6, 1'b1);
        step();
        drive_msg(1'b0, 2'd0, 56'd0, 1'b0);
        n_checks++;
        if ({ipg_tx_data, in_msg} !== {64'hC0C1C2C3C4C5C62c, 1'b0}) begin
            n_fail++; $display("FAIL multi_last: got %h in_msg %b want c0c1c2c3c4c5c62c/0", ipg_tx_data, in_msg);
        end
        n_checks++;
        if (insert_cnt !== 32'd4) begin n_fail++; $display("FAIL multi_cnt: got %0d want 4", insert_cnt); end
    endtask

    task automatic test_stall();
        drive_msg(1'b1, 2'd1, 56'h0D0D0D0D0D0D0D, 1'b1);
        drive_blk(2'b10, 64'hDEADBEEF01234567);
        #1;
        n_checks++;
        if (msg_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_data: got %b want 0", msg_ready); end
        step();
        n_checks++;
        if ({ipg_tx_hdr, ipg_tx_data} !== {2'b10, 64'hDEADBEEF01234567}) begin
            n_fail++; $display("FAIL stall_pass1: got %b/%h want 10/deadbeef01234567", ipg_tx_hdr, ipg_tx_data);
        end
        drive_blk(2'b10, 64'h0123456789ABCDEF);
        step();
        n_checks++;
        if ({ipg_tx_hdr, ipg_tx_data} !== {2'b10, 64'h0123456789ABCDEF}) begin
            n_fail++; $display("FAIL stall_pass2: got %b/%h want 10/0123456789abcdef", ipg_tx_hdr, ipg_tx_data);
        end
        drive_blk(2'b01, 64'h000000000000071e);
        #1;
        n_checks++;
        if (msg_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready_ctrl: got %b want 0", msg_ready); end
        step();
        n_checks++;
        if ({ipg_tx_hdr, ipg_tx_data} !== {2'b01, 64'h000000000000071e}) begin
            n_fail++; $display("FAIL stall_pass3: got %b/%h want 01/000000000000071e", ipg_tx_hdr, ipg_tx_data);
        end
        n_checks++;
        if (stall_cnt !== 32'd3) begin n_fail++; $display("FAIL stall_cnt: got %0d want 3", stall_cnt); end
        drive_blk(2'b01, IDLE_BLK);
        step();
        drive_msg(1'b0, 2'd0, 56'd0, 1'b0);
        n_checks++;
        if ({ipg_tx_hdr, ipg_tx_data} !== {2'b01, 64'h0D0D0D0D0D0D0D2b}) begin
            n_fail++; $display("FAIL stall_insert: got %b/%h want 01/0d0d0d0d0d0d0d2b", ipg_tx_hdr, ipg_tx_data);
        end
        n_checks++;
        if ((insert_cnt !== 32'd5) || (stall_cnt !== 32'd3)) begin
            n_fail++; $display("FAIL stall_cnts: got %0d/%0d want 5/3", insert_cnt, stall_cnt);
        end
    endtask

    task automatic test_reserved();
        drive_blk(2'b01, IDLE_BLK);
        drive_msg(1'b1, 2'd3, 56'h33333333333333, 1'b0);
        #1;
        n_checks++;
        if (msg_ready !== 1'b1) begin n_fail++; $display("FAIL rsvd_ready: got %b want 1", msg_ready); end
        step();
        n_checks++;
        if ({ipg_tx_data, type_err, in_msg} !== {IDLE_BLK, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL rsvd_first: got %h err %b in_msg %b want 1e/1/0", ipg_tx_data, type_err, in_msg);
        end
        drive_msg(1'b1, 2'd0, 56'h44444444444444, 1'b1);
        step();
        drive_msg(1'b0, 2'd0, 56'd0, 1'b0);
        n_checks++;
        if ({ipg_tx_data, type_err} !== {IDLE_BLK, 1'b0}) begin
            n_fail++; $display("FAIL rsvd_second: got %h err %b want 1e/0", ipg_tx_data, type_err);
        end
        n_checks++;
        if (insert_cnt !== 32'd5) begin n_fail++; $display("FAIL rsvd_cnt: got %0d want 5", insert_cnt); end
        drive_msg(1'b1, 2'd1, 56'h55555555555555, 1'b1);
        step();
        drive_msg(1'b0, 2'd0, 56'd0, 1'b0);
        n_checks++;
        if (ipg_tx_data !== 64'h555555555555552b) begin
            n_fail++; $display("FAIL rsvd_next: got %h want 555555555555552b", ipg_tx_data);
        end
    endtask

    task automatic test_async_reset();
        drive_blk(2'b01, IDLE_BLK);
        drive_msg(1'b1, 2'd1, 56'h66666666666666, 1'b0);
        step();
        drive_msg(1'b0, 2'd0, 56'd0, 1'b0);
        n_checks++;
        if ((in_msg !== 1'b1) || (insert_cnt !== 32'd7)) begin
            n_fail++; $display("FAIL arst_busy: got in_msg %b cnt %0d want 1/7", in_msg, insert_cnt);
        end
        drive_blk(2'b10, 64'hFEEDFACECAFEBABE);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({ipg_tx_hdr, ipg_tx_data} !== {2'b01, IDLE_BLK}) begin
            n_fail++; $display("FAIL arst_out: got %b/%h want 01/1e", ipg_tx_hdr, ipg_tx_data);
        end
        n_checks++;
        if ((in_msg !== 1'b0) || (insert_cnt !== 32'd0) || (stall_cnt !== 32'd0)) begin
            n_fail++; $display("FAIL arst_state: got in_msg %b cnt %0d/%0d want 0/0/0", in_msg, insert_cnt, stall_cnt);
        end
        #2;
        rst_n = 1'b1;
        drive_blk(2'b01, IDLE_BLK);
        drive_msg(1'b1, 2'd2, 56'h77777777777777, 1'b0);
        step();
        n_checks++;
        if ({ipg_tx_data, in_msg} !== {64'h777777777777770c, 1'b1}) begin
            n_fail++; $display("FAIL arst_first: got %h in_msg %b want 777777777777770c/1", ipg_tx_data, in_msg);
        end
        drive_msg(1'b1, 2'd2, 56'h88888888888888, 1'b1);
        step();
        drive_msg(1'b0, 2'd0, 56'd0, 1'b0);
        n_checks++;
        if ({ipg_tx_data, in_msg, insert_cnt} !== {64'h888888888888882c, 1'b0, 32'd2}) begin
            n_fail++; $display("FAIL arst_last: got %h in_msg %b cnt %0d want 888888888888882c/0/2", ipg_tx_data, in_msg, insert_cnt);
        end
    endtask

    task automatic test_saturation();
        drive_msg(1'b1, 2'd0, 56'h99999999999999, 1'b1);
        for (int i = 0; i < 20; i++) begin
            drive_blk(2'b10, {32'hA5A50000 + i, 32'h5A5A5A5A});
            step();
        end
        n_checks++;
        if (stall_cnt !== 32'd20) begin n_fail++; $display("FAIL sat_wide: got %0d want 20", stall_cnt); end
        n_checks++;
        if (s_stall_cnt !== 4'hf) begin n_fail++; $display("FAIL sat_narrow: got %h want f", s_stall_cnt); end
        n_checks++;
        if ({ipg_tx_hdr, ipg_tx_data} !== {2'b10, 64'hA5A500135A5A5A5A}) begin
            n_fail++; $display("FAIL sat_pass: got %b/%h want 10/a5a500135a5a5a5a", ipg_tx_hdr, ipg_tx_data);
        end
        n_checks++;
        if (insert_cnt !== 32'd2) begin n_fail++; $display("FAIL sat_insert: got %0d want 2", insert_cnt); end
        drive_msg(1'b0, 2'd0, 56'd0, 1'b0);
        drive_blk(2'b01, IDLE_BLK);
        step();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single();
        test_multi();
        test_stall();
        test_reserved();
        test_async_reset();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
